// File: rtl/pcie_tx_pkg.sv
// pcie_tx_pkg: TLP format/type constants, TX FSM state type and DW byte swap,
// shared between the PCIe transmit and receive paths.
package pcie_tx_pkg;

    localparam logic [6:0] CPLD   = 7'b1001010;
    localparam logic [6:0] MWR32  = 7'b1000000;
    localparam logic [9:0] LEN_DW = 10'd2;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, BEAT2} state_e;

    // Host data is little-endian; TLP payload DWs are sent byte-reversed.
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Header DW0 for a 2-DW TLP of the given fmt/type.
    function automatic logic [31:0] hdr0(input logic [6:0] fmt_type);
        return {1'b0, fmt_type, 14'd0, LEN_DW};
    endfunction

endpackage

// File: rtl/pcie_tx.sv
// pcie_tx: builds 3-beat CplD / MWr32 TLPs from register-read completions and
// posted writes, arbitrated round-robin, onto a 64-bit AXI stream.
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   completer_id                   static requester/completer ID
//   cpl_valid/cpl_ready, cpl_*     completion request (ready is a 1-cycle accept pulse)
//   wr_valid/wr_ready, wr_*        posted write request (ready is a 1-cycle accept pulse)
//   tvalid/tready/tdata/tkeep/tlast AXI stream towards the PCIe core
module pcie_tx
    import pcie_tx_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] completer_id,
    input  logic        cpl_valid,
    output logic        cpl_ready,
    input  logic [23:0] cpl_rid_tag,
    input  logic [12:0] cpl_address,
    input  logic [63:0] cpl_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [28:0] wr_address,
    input  logic [63:0] wr_data,
    output logic        tvalid,
    input  logic        tready,
    output logic [63:0] tdata,
    output logic [7:0]  tkeep,
    output logic        tlast
);

    state_e      state_q, state_d;
    logic        prefer_wr_q, prefer_wr_d;
    logic [63:0] hdr01_q, hdr01_d;
    logic [31:0] hdr2_q, hdr2_d;
    logic [63:0] pay_q, pay_d;
    logic        idle, grant_cpl, grant_wr, fire;

    assign idle      = state_q == IDLE;
    // Completions win unless a write is also pending and it is the write's turn.
    assign grant_cpl = idle && cpl_valid && (!wr_valid || !prefer_wr_q);
    assign grant_wr  = idle && wr_valid && !grant_cpl;
    assign fire      = tvalid && tready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prefer_wr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prefer_wr_q <= prefer_wr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prefer_wr_d = prefer_wr_q;
        case (state_q)
            IDLE: if (grant_cpl || grant_wr) begin
                state_d     = BEAT0;
                prefer_wr_d = grant_cpl;
            end
            BEAT0:   if (fire) state_d = BEAT1;
            BEAT1:   if (fire) state_d = BEAT2;
            default: if (fire) state_d = IDLE;
        endcase
    end

    // Whole TLP is assembled at capture so requesters may move on immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hdr01_q <= '0;
            hdr2_q  <= '0;
            pay_q   <= '0;
        end else begin
            hdr01_q <= hdr01_d;
            hdr2_q  <= hdr2_d;
            pay_q   <= pay_d;
        end
    end

    always_comb begin
        hdr01_d = hdr01_q;
        hdr2_d  = hdr2_q;
        pay_d   = pay_q;
        if (grant_cpl) begin
            hdr01_d = {completer_id, 4'h0, 12'd8, hdr0(CPLD)};
            hdr2_d  = {cpl_rid_tag, 1'b0, cpl_address[3:0], 3'b000};
            pay_d   = {bswap32(cpl_data[63:32]), bswap32(cpl_data[31:0])};
        end else if (grant_wr) begin
            hdr01_d = {completer_id, 8'h00, 8'hFF, hdr0(MWR32)};
            hdr2_d  = {wr_address, 3'b000};
            pay_d   = {bswap32(wr_data[63:32]), bswap32(wr_data[31:0])};
        end
    end

    // Ready pulses are gated by reset so they stay low while reset is held.
    always_comb begin
        cpl_ready = reset_n && grant_cpl;
        wr_ready  = reset_n && grant_wr;
        tvalid    = !idle;
        tlast     = state_q == BEAT2;
        case (state_q)
            BEAT0: begin
                tdata = hdr01_q;
                tkeep = 8'hFF;
            end
            BEAT1: begin
                tdata = {pay_q[31:0], hdr2_q};
                tkeep = 8'hFF;
            end
            BEAT2: begin
                tdata = {32'h0, pay_q[63:32]};
                tkeep = 8'h0F;
            end
            default: begin
                tdata = '0;
                tkeep = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pcie_tx.sv
// tb_pcie_tx: randomized, model-checked bench for pcie_tx with directed literal checks.
module tb_pcie_tx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] completer_id;
    logic        cpl_valid, cpl_ready;
    logic [23:0] cpl_rid_tag;
    logic [12:0] cpl_address;
    logic [63:0] cpl_data;
    logic        wr_valid, wr_ready;
    logic [28:0] wr_address;
    logic [63:0] wr_data;
    logic        tvalid, tready, tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;

    always #5 clock = ~clock;

    pcie_tx dut (
        .clock(clock), .reset_n(reset_n), .completer_id(completer_id),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_rid_tag(cpl_rid_tag),
        .cpl_address(cpl_address), .cpl_data(cpl_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_address(wr_address), .wr_data(wr_data),
        .tvalid(tvalid), .tready(tready), .tdata(tdata), .tkeep(tkeep), .tlast(tlast)
    );

    int checks = 0;
    int errors = 0;
    int tlp_done = 0;

    logic [63:0] exp_data[$];
    logic [7:0]  exp_keep[$];
    logic        exp_last[$];
    logic [63:0] log_data[$];
    logic [7:0]  log_keep[$];
    logic        log_last[$];
    int          log_type[$];

    logic        last_wr = 1'b0;
    logic        have_prev = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] swap(input logic [31:0] x);
        swap = {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Reference TLP from the currently presented request fields.
    task automatic push_tlp(input logic wr);
        logic [31:0] h0, h1, h2;
        logic [63:0] d;
        if (wr) begin
            h0 = 32'h4000_0002;
            h1 = {completer_id, 16'h00FF};
            h2 = {wr_address, 3'b000};
            d  = wr_data;
        end else begin
            h0 = 32'h4A00_0002;
            h1 = {completer_id, 16'h0008};
            h2 = {cpl_rid_tag, 1'b0, cpl_address[3:0], 3'b000};
            d  = cpl_data;
        end
        exp_data.push_back({h1, h0});               exp_keep.push_back(8'hFF); exp_last.push_back(1'b0);
        exp_data.push_back({swap(d[31:0]), h2});    exp_keep.push_back(8'hFF); exp_last.push_back(1'b0);
        exp_data.push_back({32'h0, swap(d[63:32])}); exp_keep.push_back(8'h0F); exp_last.push_back(1'b1);
    endtask

    always @(negedge clock) begin
        logic exp_wr;
        if (!reset_n) begin
            exp_data.delete(); exp_keep.delete(); exp_last.delete();
            last_wr   = 1'b0;
            have_prev = 1'b0;
            chk("reset_ctrl", {tvalid, tlast, cpl_ready, wr_ready, tkeep}, 64'h0);
            chk("reset_tdata", tdata, 64'h0);
        end else begin
            if (have_prev) begin
                chk("stall_tvalid", tvalid, 1);
                chk("stall_tdata", tdata, prev_data);
                chk("stall_tkeep", tkeep, prev_keep);
                chk("stall_tlast", tlast, prev_last);
            end
            chk("ready_exclusive", cpl_ready && wr_ready, 0);
            if (exp_data.size() != 0) begin
                chk("tvalid_busy", tvalid, 1);
                chk("ready_busy", cpl_ready || wr_ready, 0);
                if (tvalid) begin
                    chk("beat_tdata", tdata, exp_data[0]);
                    chk("beat_tkeep", tkeep, exp_keep[0]);
                    chk("beat_tlast", tlast, exp_last[0]);
                    if (tready) begin
                        log_data.push_back(tdata); log_keep.push_back(tkeep); log_last.push_back(tlast);
                        void'(exp_data.pop_front()); void'(exp_keep.pop_front()); void'(exp_last.pop_front());
                        if (tlast) tlp_done++;
                    end
                end
            end else begin
                chk("tvalid_idle", tvalid, 0);
                if (cpl_valid || wr_valid) begin
                    exp_wr = (cpl_valid && wr_valid) ? !last_wr : wr_valid;
                    chk("grant_cpl", cpl_ready, !exp_wr);
                    chk("grant_wr", wr_ready, exp_wr);
                    log_type.push_back(int'(wr_ready));
                    push_tlp(exp_wr);
                    last_wr = exp_wr;
                end else begin
                    chk("ready_noreq", cpl_ready || wr_ready, 0);
                end
            end
            have_prev = tvalid && !tready;
            prev_data = tdata;
            prev_keep = tkeep;
            prev_last = tlast;
        end
    end

    task automatic wait_ready(input logic wr, input string name);
        logic got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = wr ? wr_ready : cpl_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no ready within 50 cycles, got 0 expected 1", name);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_tlps(input int target, input string name);
        for (int i = 0; i < 300 && tlp_done < target; i++) @(posedge clock);
        chk(name, 64'(tlp_done), 64'(target));
    endtask

    task automatic rnd_phase(input int n);
        logic sc, sr;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sc = cpl_ready;
            sr = wr_ready;
            @(posedge clock);
            #1;
            if (!cpl_valid || sc) begin
                cpl_valid   = ($urandom % 3) == 0;
                cpl_rid_tag = 24'($urandom);
                cpl_address = 13'($urandom);
                cpl_data    = {$urandom, $urandom};
            end
            if (!wr_valid || sr) begin
                wr_valid   = ($urandom % 3) == 0;
                wr_address = 29'($urandom);
                wr_data    = {$urandom, $urandom};
            end
            tready = ($urandom % 4) != 0;
        end
    endtask

    initial begin
        int b, base, nlog, cnt;
        completer_id = 16'h0200;
        cpl_valid = 1'b1; wr_valid = 1'b1; tready = 1'b1;
        cpl_rid_tag = '0; cpl_address = '0; cpl_data = '0;
        wr_address = '0; wr_data = '0;
        repeat (3) @(posedge clock);
        #1;
        cpl_valid = 1'b0; wr_valid = 1'b0; reset_n = 1'b1;
        @(posedge clock);
        #1;

        cpl_rid_tag = 24'h0100A5; cpl_address = 13'h0003; cpl_data = 64'h1122334455667788;
        cpl_valid = 1'b1;
        wait_ready(1'b0, "cpl_ready_timeout");
        cpl_valid = 1'b0;
        cpl_rid_tag = 24'hFFFFFF; cpl_address = 13'h1FFF; cpl_data = '1;
        wait_tlps(1, "cpl_tlp_count");
        b = log_data.size() - 3;
        chk("cpl_beat0", log_data[b], 64'h02000008_4A000002);
        chk("cpl_beat1", log_data[b+1], 64'h88776655_0100A518);
        chk("cpl_beat2_lo", log_data[b+2][31:0], 32'h44332211);
        chk("cpl_beat2_keep", log_keep[b+2], 8'h0F);
        chk("cpl_beat2_last", log_last[b+2], 1);
        chk("cpl_beat1_last", log_last[b+1], 0);

        wr_address = 29'h02000001; wr_data = 64'h0;
        wr_valid = 1'b1;
        wait_ready(1'b1, "wr_ready_timeout");
        wr_valid = 1'b0;
        wr_address = 29'h1ABCDEF0; wr_data = 64'hDEADBEEF_CAFEF00D;
        wait_tlps(2, "wr_tlp_count");
        b = log_data.size() - 3;
        chk("wr_beat0", log_data[b], 64'h020000FF_40000002);
        chk("wr_beat1", log_data[b+1], 64'h00000000_10000008);
        chk("wr_beat2", log_data[b+2], 64'h0);

        cpl_rid_tag = 24'h123456; cpl_address = 13'h0ABC; cpl_data = 64'h0102030405060708;
        wr_address = 29'h0000FFFF; wr_data = 64'h8877665544332211;
        cpl_valid = 1'b1; wr_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 4; i++) begin
            @(negedge clock);
            if (cpl_ready || wr_ready) cnt++;
        end
        @(posedge clock);
        #1;
        cpl_valid = 1'b0; wr_valid = 1'b0;
        chk("arb_grants", 64'(cnt), 64'd4);
        wait_tlps(6, "arb_tlp_count");
        b = log_type.size() - 4;
        chk("arb_type0", 64'(log_type[b]), 0);
        chk("arb_type1", 64'(log_type[b+1]), 1);
        chk("arb_type2", 64'(log_type[b+2]), 0);
        chk("arb_type3", 64'(log_type[b+3]), 1);

        completer_id = 16'hBEEF;
        rnd_phase(3000);
        cpl_valid = 1'b0; wr_valid = 1'b0; tready = 1'b1;
        for (int i = 0; i < 20 && exp_data.size() != 0; i++) @(posedge clock);
        chk("rnd_drain", 64'(exp_data.size()), 0);
        chk("rnd_progress", 64'(tlp_done > 100), 1);

        completer_id = 16'h0200;
        @(posedge clock);
        #1;
        cpl_rid_tag = 24'hABCDEF; cpl_address = 13'h0005; cpl_data = 64'h0F0E0D0C0B0A0908;
        cpl_valid = 1'b1;
        wait_ready(1'b0, "mid_ready_timeout");
        cpl_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_tvalid", tvalid, 0);
        chk("mid_reset_tdata", tdata, 64'h0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        base = tlp_done;
        nlog = log_data.size();
        @(posedge clock);
        #1;
        chk("post_reset_quiet", 64'(log_data.size() - nlog), 0);
        wr_address = 29'h02000001; wr_data = 64'h0;
        wr_valid = 1'b1;
        wait_ready(1'b1, "post_reset_ready_timeout");
        wr_valid = 1'b0;
        wait_tlps(base + 1, "post_reset_tlp_count");
        chk("post_reset_beats", 64'(log_data.size() - nlog), 3);
        b = log_data.size() - 3;
        chk("post_reset_beat0", log_data[b], 64'h020000FF_40000002);
        chk("post_reset_beat1", log_data[b+1], 64'h00000000_10000008);

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
